// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: synthetic DVP camera source for bring-up without a sensor.
// Emits frames of VSYNC, front porch, V_ACTIVE lines of (active + H_BLANK),
// and a back porch, one byte per clk_cmos. All outputs are registered.
// Ports:
//   clk_cmos    byte clock
//   rst         synchronous active-high reset
//   en          run frames continuously while high (frames never truncated)
//   pat_sel     test pattern select, latched at frame start
//   cmos_vsync  frame sync, active high
//   cmos_href   line valid, high during active bytes
//   cmos_data   pixel byte, 0 while href is low
//   frame_done  one-cycle pulse on the last cycle of each frame
//   frame_cnt   completed frame count (wraps)
//   busy        high whenever the FSM is not idle
module dvp_frame_tx #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 960,
  parameter int BPP       = 1,
  parameter int H_BLANK   = 160,
  parameter int VSYNC_LEN = 8,
  parameter int V_FRONT   = 16,
  parameter int V_BACK    = 16
) (
  input  logic        clk_cmos,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BM0   = (H_BLANK > VSYNC_LEN) ? H_BLANK : VSYNC_LEN;
  localparam int BM1   = (V_FRONT > V_BACK) ? V_FRONT : V_BACK;
  localparam int BMAX  = (BM0 > BM1) ? BM0 : BM1;
  localparam int CW    = $clog2(BMAX + 1);

  localparam logic [CW-1:0] VS_LAST = CW'(VSYNC_LEN - 1);
  localparam logic [CW-1:0] VF_LAST = CW'(V_FRONT - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(V_BACK - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VFRONT = 3'd2;
  localparam logic [2:0] S_LINE   = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VBACK  = 3'd5;

  logic [2:0]    st, nxt_st;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [XW-1:0] x, nxt_x;
  logic [YW-1:0] y, nxt_y;
  logic          ph, nxt_ph;     // byte phase for BPP=2: 0 = high byte
  logic [1:0]    pat_q, nxt_pat;
  logic          last_cyc;       // current cycle is the final cycle of a frame
  logic [7:0]    nxt_x8, nxt_y8, p8, nxt_byte;

  // Next-state logic. Outputs are registered from the next-state values so
  // they line up with the state they describe, not one cycle behind it.
  always_comb begin
    nxt_st   = st;
    nxt_cnt  = cnt;
    nxt_x    = x;
    nxt_y    = y;
    nxt_ph   = ph;
    nxt_pat  = pat_q;
    last_cyc = 1'b0;
    case (st)
      S_IDLE: begin
        if (en) begin
          nxt_st  = S_VSYNC;
          nxt_cnt = '0;
          nxt_pat = pat_sel;
        end
      end
      S_VSYNC: begin
        if (cnt == VS_LAST) begin
          nxt_st  = S_VFRONT;
          nxt_cnt = '0;
        end else nxt_cnt = cnt + 1'b1;
      end
      S_VFRONT: begin
        if (cnt == VF_LAST) begin
          nxt_st = S_LINE;
          nxt_x  = '0;
          nxt_y  = '0;
          nxt_ph = 1'b0;
        end else nxt_cnt = cnt + 1'b1;
      end
      S_LINE: begin
        if (BPP == 2 && !ph) nxt_ph = 1'b1;
        else begin
          nxt_ph = 1'b0;
          if (x == X_LAST) begin
            nxt_st  = S_HBLANK;
            nxt_cnt = '0;
          end else nxt_x = x + 1'b1;
        end
      end
      S_HBLANK: begin
        if (cnt == HB_LAST) begin
          nxt_cnt = '0;
          if (y != Y_LAST) begin
            nxt_st = S_LINE;
            nxt_y  = y + 1'b1;
            nxt_x  = '0;
            nxt_ph = 1'b0;
          end else nxt_st = S_VBACK;
        end else nxt_cnt = cnt + 1'b1;
      end
      S_VBACK: begin
        if (cnt == VB_LAST) begin
          last_cyc = 1'b1;
          nxt_cnt  = '0;
          if (en) begin
            nxt_st  = S_VSYNC;
            nxt_pat = pat_sel;
          end else nxt_st = S_IDLE;
        end else nxt_cnt = cnt + 1'b1;
      end
      default: nxt_st = S_IDLE;
    endcase
  end

  // Zero-extend / truncate the pixel coordinates to 8 bits.
  generate
    if (XW >= 8) begin : g_x8
      assign nxt_x8 = nxt_x[7:0];
    end else begin : g_x8
      assign nxt_x8 = {{(8-XW){1'b0}}, nxt_x};
    end
    if (YW >= 8) begin : g_y8
      assign nxt_y8 = nxt_y[7:0];
    end else begin : g_y8
      assign nxt_y8 = {{(8-YW){1'b0}}, nxt_y};
    end
  endgenerate

  // frame_cnt is stable for the whole frame, so pattern 3 is flat.
  always_comb begin
    case (nxt_pat)
      2'd0:    p8 = nxt_x8;
      2'd1:    p8 = nxt_y8;
      2'd2:    p8 = nxt_x8 ^ nxt_y8;
      default: p8 = frame_cnt[7:0];
    endcase
    nxt_byte = (BPP == 2 && nxt_ph) ? ~p8 : p8;
  end

  always_ff @(posedge clk_cmos) begin
    if (rst) begin
      st         <= S_IDLE;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      ph         <= 1'b0;
      pat_q      <= 2'd0;
      frame_cnt  <= 16'd0;
      cmos_vsync <= 1'b0;
      cmos_href  <= 1'b0;
      cmos_data  <= 8'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      st         <= nxt_st;
      cnt        <= nxt_cnt;
      x          <= nxt_x;
      y          <= nxt_y;
      ph         <= nxt_ph;
      pat_q      <= nxt_pat;
      if (last_cyc) frame_cnt <= frame_cnt + 16'd1;
      cmos_vsync <= (nxt_st == S_VSYNC);
      cmos_href  <= (nxt_st == S_LINE);
      cmos_data  <= (nxt_st == S_LINE) ? nxt_byte : 8'd0;
      // pulse spans the final back-porch cycle, the same cycle whose end
      // bumps frame_cnt
      frame_done <= (nxt_st == S_VBACK) && (nxt_cnt == VB_LAST);
      busy       <= (nxt_st != S_IDLE);
    end
  end

endmodule
